gpio_bank: RTL
==============

# gpio_bank

Parametrised GPIO peripheral on the processor's memory-mapped bus: per-pin direction, output value with atomic set/clear/toggle, synchronised input sampling, and per-pin rising/falling edge interrupts with a write-1-to-clear pending register. It is the next-generation replacement for the fixed 8-pin GPIO block. It sits behind the bus address decoder and drives the pad-level output and output-enable signals.

## Interface

- WIDTH, 8: number of pins; legal range 1..32.
- SYNC_STAGES, 2: input synchroniser depth; legal range 2..4.

- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset; clears all state immediately.
- read  in  1  bus read strobe.
- write  in  1  bus write strobe.
- address  in  32  byte address; only address[5:2] is decoded (word offset).
- write_data  in  32  write data; bits [31:WIDTH] ignored.
- read_data  out  32  read data; combinational.
- gpios_in  in  WIDTH  asynchronous pad inputs.
- gpios_out  out  WIDTH  pad output values (equals OUT).
- direction  out  WIDTH  pad output enables (equals DIR; 1 = output).
- irq  out  1  interrupt request; OR of IP.

## Operation

- Register map (offset = address[5:2]):
  - 0 DIR, rw.
  - 1 OUT, rw.
  - 2 OUT_SET, wo: OUT |= data.
  - 3 OUT_CLR, wo: OUT &= ~data.
  - 4 OUT_TGL, wo: OUT ^= data.
  - 5 IN, ro: synchronised pin values.
  - 6 RISE_IE, rw.
  - 7 FALL_IE, rw.
  - 8 IP, read pending; write-1-to-clear.
  - 9..15: reserved; reads 0, writes ignored.
- read_data = 0 when read is low, for write-only and reserved offsets, and in bits [31:WIDTH].
- Writes to read-only offsets (IN) are ignored.
- Input path:
  - Each pin passes through a SYNC_STAGES-flop chain; the last stage is `sync`, which IN reads.
  - A further register `prev` holds `sync` from the previous cycle.
  - rise = sync & ~prev; fall = ~sync & prev.
- Pending update, per bit per cycle: IP_next = (IP & ~clr) | (rise & RISE_IE) | (fall & FALL_IE). clr = write_data when writing offset 8, else 0.
  - Set has priority over a simultaneous W1C of the same bit.
- IE changes do not alter IP. Disabling an enable leaves existing pending bits set.
- IN samples all pins regardless of DIR, so output pins read back through the synchroniser.
- gpios_out is driven from OUT even for input pins; the pad gates it with direction.

## Timing

- Reset values: DIR, OUT, RISE_IE, FALL_IE, IP, synchroniser and prev all 0. Therefore gpios_out = 0, direction = 0, irq = 0, read_data = 0 (read low).
- Reset asserted mid-operation clears everything asynchronously. The first write after release takes effect on the first clk edge with reset low.
- Register writes take effect at the clk edge where write is high. A same-cycle read returns the pre-write value.
- gpios_out and direction change one edge after the write.
- Pin change to IN: visible after SYNC_STAGES edges.
- Pin change to IP/irq: IP set on edge SYNC_STAGES+1; irq is high in the same cycle, since it is combinational from IP.
- IP W1C: the bit clears on the write edge, and irq drops the same cycle if no other bit is pending.
- A pin held high through reset release produces a rise event SYNC_STAGES edges later. It only sets IP if RISE_IE is already 1 at that edge (it is 0 after reset).
- Toggling faster than one edge per cycle after synchronisation is not detected. Each synchronised transition yields exactly one event.

## Test plan

- Reset, then write DIR=0xF0 and OUT=0xA5 -> direction=0xF0, gpios_out=0xA5 one cycle later; read offset 1 returns 0x000000A5.
- From OUT=0xA5: SET 0x0A -> 0xAF; CLR 0x81 -> 0x2E; TGL 0xFF -> 0xD1. Read of offset 2 returns 0.
- gpios_in 0x00 -> 0x3C with SYNC_STAGES=2 -> IN reads 0x00 after 1 edge and 0x3C after 2 edges.
- RISE_IE=0x04, FALL_IE=0x08; pin2 rises -> IP=0x04 and irq=1 at edge 3. Pin3 falls -> IP=0x0C. W1C 0x04 -> IP=0x08, irq still 1.
- Pin2 rise event on the same edge as W1C 0x04 -> IP[2] remains 1.
- Assert reset asynchronously between clk edges with IP=0xFF and OUT=0xFF -> all outputs 0 immediately. WIDTH=32 regression: write 0xFFFFFFFF to OUT -> reads back 0xFFFFFFFF.

Source files
------------

// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank: per-pin direction, output with set/clear/toggle,
// synchronised input sampling and rise/fall edge interrupts with W1C pending.
module gpio_bank #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      address,
    input  logic [31:0]      write_data,
    output logic [31:0]      read_data,
    input  logic [WIDTH-1:0] gpios_in,
    output logic [WIDTH-1:0] gpios_out,
    output logic [WIDTH-1:0] direction,
    output logic             irq
);

    localparam logic [3:0] OFF_DIR     = 4'd0;
    localparam logic [3:0] OFF_OUT     = 4'd1;
    localparam logic [3:0] OFF_OUT_SET = 4'd2;
    localparam logic [3:0] OFF_OUT_CLR = 4'd3;
    localparam logic [3:0] OFF_OUT_TGL = 4'd4;
    localparam logic [3:0] OFF_IN      = 4'd5;
    localparam logic [3:0] OFF_RISE_IE = 4'd6;
    localparam logic [3:0] OFF_FALL_IE = 4'd7;
    localparam logic [3:0] OFF_IP      = 4'd8;

    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_rise_ie;
    logic [WIDTH-1:0] r_fall_ie;
    logic [WIDTH-1:0] r_ip;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_sync [SYNC_STAGES];

    logic [3:0]       w_off;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_in;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_rd;
    logic             w_unused;

    assign w_off    = address[5:2];
    assign w_wdata  = write_data[WIDTH-1:0];
    assign w_in     = r_sync[SYNC_STAGES-1];
    assign w_rise   = w_in & ~r_prev;
    assign w_fall   = ~w_in & r_prev;
    assign w_clr    = (write && (w_off == OFF_IP)) ? w_wdata : '0;
    assign w_unused = ^{address[31:6], address[1:0], write_data};

    assign gpios_out = r_out;
    assign direction = r_dir;
    assign irq       = |r_ip;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
            r_prev <= '0;
        end else begin
            r_sync[0] <= gpios_in;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_prev <= w_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dir     <= '0;
            r_out     <= '0;
            r_rise_ie <= '0;
            r_fall_ie <= '0;
            r_ip      <= '0;
        end else begin
            // new edge events win over a W1C of the same bit
            r_ip <= (r_ip & ~w_clr) | (w_rise & r_rise_ie) | (w_fall & r_fall_ie);
            if (write) begin
                case (w_off)
                    OFF_DIR:     r_dir     <= w_wdata;
                    OFF_OUT:     r_out     <= w_wdata;
                    OFF_OUT_SET: r_out     <= r_out | w_wdata;
                    OFF_OUT_CLR: r_out     <= r_out & ~w_wdata;
                    OFF_OUT_TGL: r_out     <= r_out ^ w_wdata;
                    OFF_RISE_IE: r_rise_ie <= w_wdata;
                    OFF_FALL_IE: r_fall_ie <= w_wdata;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_rd      = '0;
        read_data = '0;
        if (read) begin
            case (w_off)
                OFF_DIR:     w_rd = r_dir;
                OFF_OUT:     w_rd = r_out;
                OFF_IN:      w_rd = w_in;
                OFF_RISE_IE: w_rd = r_rise_ie;
                OFF_FALL_IE: w_rd = r_fall_ie;
                OFF_IP:      w_rd = r_ip;
                default:     w_rd = '0;
            endcase
        end
        read_data[WIDTH-1:0] = w_rd;
    end

endmodule
